calc_unit_arbiter: RTL and testbench

CALC_UNIT_ARBITER -- requirements
Module: calc_unit_arbiter

---
 rtl/calc_pkg.sv | 27 ++
 rtl/rr_pick3.sv | 34 +++
 rtl/calc_unit_arbiter.sv | 157 +++++++++++++++
 tb/tb_calc_unit_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calc-unit arbiter: FSM encoding, op-code fields,
// datapath widths and the one-hot to index helper.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int         DATA_W              = 40;
  localparam int         CNT_W               = 12;
  localparam int         DEFAULT_TIMEOUT_CYC = 4095;
  localparam logic [2:0] OP_SQRT             = 3'b100;

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first set request searching circularly
// from the requester after last_i. Purely combinational.
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o
);

  // Rotate the priority order so the requester after last_i is checked first
  always_comb begin
    gnt_o = 3'b000;
    case (last_i)
      2'd0: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else               gnt_o = 3'b000;
      end
      2'd1: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else               gnt_o = 3'b000;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else               gnt_o = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/calc_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle arithmetic unit between three
// requesters, with a watchdog that aborts the unit after TIMEOUT_CYC waits.
module calc_unit_arbiter
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int NREQ        = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [2:0]        OP0,
  input  logic [2:0]        OP1,
  input  logic [2:0]        OP2,
  input  logic [DATA_W-1:0] IN0,
  input  logic [DATA_W-1:0] IN1,
  input  logic [DATA_W-1:0] IN2,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   ACK,
  output logic [DATA_W-1:0] RES,
  output logic              RES_COUT,
  output logic              ERR,
  output logic              BUSY,
  output logic              U_START,
  output logic [2:0]        U_OP,
  output logic [DATA_W-1:0] U_IN,
  output logic              U_ABORT,
  input  logic [DATA_W-1:0] U_OUT,
  input  logic              U_COUT,
  input  logic              U_DONE
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d, ack_q, ack_d, u_op_q, u_op_d;
  logic [DATA_W-1:0] u_in_q, u_in_d, res_q, res_d;
  logic              res_cout_q, res_cout_d, err_q, err_d;
  logic              u_start_q, u_start_d, u_abort_q, u_abort_d;
  logic [1:0]        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        pick_s;

  rr_pick3 u_pick (
    .req_i  (REQ),
    .last_i (last_q),
    .gnt_o  (pick_s)
  );

  // Next-state and output decode; pulses default low, everything else holds
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = 3'b000;
    u_op_d     = u_op_q;
    u_in_d     = u_in_q;
    res_d      = res_q;
    res_cout_d = res_cout_q;
    err_d      = err_q;
    u_start_d  = 1'b0;
    u_abort_d  = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ != 3'b000) begin
          gnt_d     = pick_s;
          u_start_d = 1'b1;
          state_d   = ST_ISSUE;
          case (onehot_idx(pick_s))
            2'd0:    begin u_op_d = OP0; u_in_d = IN0; end
            2'd1:    begin u_op_d = OP1; u_in_d = IN1; end
            default: begin u_op_d = OP2; u_in_d = IN2; end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done wins over a coincident timeout
        if (U_DONE) begin
          res_d      = U_OUT;
          res_cout_d = U_COUT;
          err_d      = 1'b0;
          ack_d      = gnt_q;
          state_d    = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          res_d      = {DATA_W{1'b0}};
          res_cout_d = 1'b0;
          err_d      = 1'b1;
          u_abort_d  = 1'b1;
          ack_d      = gnt_q;
          state_d    = ST_RESP;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 12'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESP: begin
        gnt_d   = 3'b000;
        last_d  = onehot_idx(gnt_q);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 3'b000;
      ack_q      <= 3'b000;
      u_op_q     <= 3'b000;
      u_in_q     <= {DATA_W{1'b0}};
      res_q      <= {DATA_W{1'b0}};
      res_cout_q <= 1'b0;
      err_q      <= 1'b0;
      u_start_q  <= 1'b0;
      u_abort_q  <= 1'b0;
      last_q     <= 2'd2;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      u_op_q     <= u_op_d;
      u_in_q     <= u_in_d;
      res_q      <= res_d;
      res_cout_q <= res_cout_d;
      err_q      <= err_d;
      u_start_q  <= u_start_d;
      u_abort_q  <= u_abort_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign GNT      = gnt_q;
  assign ACK      = ack_q;
  assign RES      = res_q;
  assign RES_COUT = res_cout_q;
  assign ERR      = err_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign U_START  = u_start_q;
  assign U_OP     = u_op_q;
  assign U_IN     = u_in_q;
  assign U_ABORT  = u_abort_q;

endmodule

// File: tb/tb_calc_unit_arbiter.sv
// Scoreboard bench for calc_unit_arbiter: stimulus queues expected grants and
// responses, a monitor checks them when U_START / ACK appear.
module tb_calc_unit_arbiter;
  import calc_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  REQ = 3'b000;
  logic [2:0]  OP0 = 3'b000, OP1 = 3'b000, OP2 = 3'b000;
  logic [39:0] IN0 = 40'd0, IN1 = 40'd0, IN2 = 40'd0;
  logic [2:0]  GNT, ACK, U_OP;
  logic [39:0] RES, U_IN;
  logic        RES_COUT, ERR, BUSY, U_START, U_ABORT;
  logic [39:0] U_OUT = 40'd0;
  logic        U_COUT = 1'b0;
  logic        U_DONE = 1'b0;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [2:0]  op;
    logic [39:0] in;
  } grant_t;

  typedef struct packed {
    logic [2:0]  ack;
    logic [39:0] res;
    logic        cout;
    logic        err;
    logic        abort;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  int          unit_lat  = 0;
  logic [39:0] unit_out  = 40'd0;
  logic        unit_cout = 1'b0;
  bit          force_done = 1'b0;

  calc_unit_arbiter #(.TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .OP0(OP0), .OP1(OP1), .OP2(OP2),
    .IN0(IN0), .IN1(IN1), .IN2(IN2),
    .GNT(GNT), .ACK(ACK), .RES(RES), .RES_COUT(RES_COUT), .ERR(ERR), .BUSY(BUSY),
    .U_START(U_START), .U_OP(U_OP), .U_IN(U_IN), .U_ABORT(U_ABORT),
    .U_OUT(U_OUT), .U_COUT(U_COUT), .U_DONE(U_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_op(input logic [2:0] g, input logic [2:0] op, input logic [39:0] in,
                           input logic [39:0] res, input logic cout, input logic err,
                           input logic abort);
    grant_t gr;
    resp_t  rs;
    gr = '{gnt: g, op: op, in: in};
    rs = '{ack: g, res: res, cout: cout, err: err, abort: abort};
    grant_q.push_back(gr);
    resp_q.push_back(rs);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!U_START && n < 50);
    if (!U_START) begin
      n_checks++;
      $display("FAIL start_timeout: no U_START within %0d cycles", n);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin @(negedge CLK); n++; end while (ACK == 3'b000 && n < 200);
    if (ACK == 3'b000) begin
      n_checks++;
      $display("FAIL ack_timeout: no ACK within %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Behavioural arithmetic unit: fixed latency after U_START, 0 = never done
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(negedge CLK);
      U_DONE = 1'b0;
      if (force_done) begin
        U_DONE = 1'b1;
        force_done = 1'b0;
      end else if (RST || U_ABORT) begin
        cd = 0;
      end else if (U_START) begin
        cd = unit_lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          U_DONE = 1'b1;
          U_OUT  = unit_out;
          U_COUT = unit_cout;
        end
      end
    end
  end

  // Monitor: pop expected grant on U_START and expected response on ACK
  initial begin
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge CLK);
      if (!RST && U_START) begin
        if (grant_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_start: GNT=%0b with no grant expected", GNT);
        end else begin
          g = grant_q.pop_front();
          chk("start_gnt", {61'd0, GNT}, {61'd0, g.gnt});
          chk("start_uop", {61'd0, U_OP}, {61'd0, g.op});
          chk("start_uin", {24'd0, U_IN}, {24'd0, g.in});
        end
      end
      if (!RST && ACK != 3'b000) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: ACK=%0b with no response expected", ACK);
        end else begin
          r = resp_q.pop_front();
          chk("ack", {61'd0, ACK}, {61'd0, r.ack});
          chk("res", {24'd0, RES}, {24'd0, r.res});
          chk("res_cout", {63'd0, RES_COUT}, {63'd0, r.cout});
          chk("err", {63'd0, ERR}, {63'd0, r.err});
          chk("abort", {63'd0, U_ABORT}, {63'd0, r.abort});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n;
    logic [39:0] in0_orig;

    repeat (2) @(negedge CLK);
    chk("rst_gnt", {61'd0, GNT}, 64'd0);
    chk("rst_ack", {61'd0, ACK}, 64'd0);
    chk("rst_ustart", {63'd0, U_START}, 64'd0);
    chk("rst_uabort", {63'd0, U_ABORT}, 64'd0);
    chk("rst_uop", {61'd0, U_OP}, 64'd0);
    chk("rst_uin", {24'd0, U_IN}, 64'd0);
    chk("rst_res", {24'd0, RES}, 64'd0);
    chk("rst_cout", {63'd0, RES_COUT}, 64'd0);
    chk("rst_err", {63'd0, ERR}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single request, unit answers 12 after 4 cycles
    OP0 = 3'b000; IN0 = 40'd5;
    OP1 = OP_SQRT | 3'b001; IN1 = 40'h00_0000_0100;
    OP2 = 3'b010; IN2 = 40'hFF_FFFF_FFFF;
    unit_lat = 4; unit_out = 40'd12; unit_cout = 1'b0;
    expect_op(3'b001, 3'b000, 40'd5, 40'd12, 1'b0, 1'b0, 1'b0);
    REQ = 3'b001;
    @(negedge CLK);
    chk("single_start_latency", {63'd0, U_START}, 64'd1);
    chk("single_busy", {63'd0, BUSY}, 64'd1);
    REQ = 3'b000;
    wait_ack(n);
    chk("single_ack_latency", 64'(n), 64'd5);
    @(negedge CLK);

    // Contention after reset: 001, 010, 100, 001
    do_reset();
    unit_lat = 2; unit_out = 40'hAB_CDEF_0123; unit_cout = 1'b1;
    expect_op(3'b001, OP0, IN0, 40'hAB_CDEF_0123, 1'b1, 1'b0, 1'b0);
    expect_op(3'b010, OP1, IN1, 40'hAB_CDEF_0123, 1'b1, 1'b0, 1'b0);
    expect_op(3'b100, OP2, IN2, 40'hAB_CDEF_0123, 1'b1, 1'b0, 1'b0);
    expect_op(3'b001, OP0, IN0, 40'hAB_CDEF_0123, 1'b1, 1'b0, 1'b0);
    REQ = 3'b111;
    for (int i = 0; i < 4; i++) wait_ack(n);
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    chk("cont_idle_busy", {63'd0, BUSY}, 64'd0);

    // Timeout: unit never answers, abort after 8 WAIT cycles
    unit_lat = 0;
    expect_op(3'b100, OP2, IN2, 40'd0, 1'b0, 1'b1, 1'b1);
    REQ = 3'b100;
    wait_start();
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    chk("hold_res", {24'd0, RES}, 64'h00AB_CDEF_0123);
    chk("hold_cout", {63'd0, RES_COUT}, 64'd1);
    wait_ack(n);
    chk("timeout_latency", 64'(n + 2), 64'd9);
    @(negedge CLK);
    chk("abort_one_cycle", {63'd0, U_ABORT}, 64'd0);

    // Done coincident with the timeout cycle resolves as done
    unit_lat = 8; unit_out = 40'h12_3456_789A; unit_cout = 1'b0;
    expect_op(3'b001, OP0, IN0, 40'h12_3456_789A, 1'b0, 1'b0, 1'b0);
    REQ = 3'b001;
    wait_start();
    REQ = 3'b000;
    wait_ack(n);
    chk("coincident_latency", 64'(n), 64'd9);
    @(negedge CLK);

    // Requester drops REQ and changes its inputs mid-operation
    unit_lat = 5; unit_out = 40'h777; unit_cout = 1'b1;
    in0_orig = 40'h55_0000_00AA;
    IN0 = in0_orig;
    expect_op(3'b001, 3'b000, in0_orig, 40'h777, 1'b1, 1'b0, 1'b0);
    REQ = 3'b001;
    wait_start();
    REQ = 3'b000; IN0 = ~in0_orig; OP0 = 3'b111;
    repeat (2) @(negedge CLK);
    chk("drop_uin_stable", {24'd0, U_IN}, {24'd0, in0_orig});
    chk("drop_uop_stable", {61'd0, U_OP}, 64'd0);
    wait_ack(n);
    @(negedge CLK);

    // U_DONE while idle must be ignored
    force_done = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_done_busy", {63'd0, BUSY}, 64'd0);
    chk("idle_done_res", {24'd0, RES}, 64'h777);

    // Reset during WAIT: everything clears at once, no ACK, then normal grant
    unit_lat = 6;
    grant_q.push_back('{gnt: 3'b010, op: OP1, in: IN1});
    REQ = 3'b010;
    wait_start();
    REQ = 3'b000;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst_gnt", {61'd0, GNT}, 64'd0);
    chk("midrst_busy", {63'd0, BUSY}, 64'd0);
    chk("midrst_res", {24'd0, RES}, 64'd0);
    chk("midrst_uin", {24'd0, U_IN}, 64'd0);
    chk("midrst_cout", {63'd0, RES_COUT}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    unit_lat = 3; unit_out = 40'h42; unit_cout = 1'b0;
    expect_op(3'b010, OP1, IN1, 40'h42, 1'b0, 1'b0, 1'b0);
    REQ = 3'b010;
    wait_start();
    REQ = 3'b000;
    wait_ack(n);
    chk("post_rst_latency", 64'(n), 64'd4);

    repeat (5) @(negedge CLK);
    chk("grant_queue_drained", 64'(grant_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
